// File: rtl/jk_register_bank.sv
// jk_register_bank
//   WIDTH-bit bank of independent JK flip-flops. Each bit can be held, cleared, set or
//   toggled by its J/K pair when en is high. A synchronous parallel load overrides JK
//   updates. A registered change pulse and a saturating change-event counter follow Q.
//
// Ports:
//   clk        in   clock, rising-edge active
//   reset      in   synchronous active-high reset (overrides everything)
//   en         in   JK update enable
//   load       in   parallel load strobe (wins over en/J/K)
//   load_data  in   [WIDTH] value loaded into Q
//   J, K       in   [WIDTH] per-bit JK controls
//   tmask      in   [WIDTH] per-bit toggle enable (only with JK_BANK_TOGGLE_MASK_EN)
//   cnt_clr    in   synchronous clear of change_cnt
//   Q          out  [WIDTH] bank state
//   changed    out  high for the cycle in which Q first shows a new value
//   change_cnt out  [CNT_W] saturating count of cycles in which Q changed
//
// Build option:
//   JK_BANK_TOGGLE_MASK_EN  adds tmask; bits with tmask[i]=0 treat JK=11 as hold.

module jk_register_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
`ifdef JK_BANK_TOGGLE_MASK_EN
    input  logic [WIDTH-1:0] tmask,
`endif
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] Q,
    output logic             changed,
    output logic [CNT_W-1:0] change_cnt
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] toggle_en;
    logic             q_change;

`ifdef JK_BANK_TOGGLE_MASK_EN
    assign toggle_en = tmask;
`else
    assign toggle_en = {WIDTH{1'b1}};
`endif

    // Next-state for the bank: load > JK (when enabled) > hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                unique case ({J[i], K[i]})
                    2'b00: q_d[i] = q_q[i];
                    2'b01: q_d[i] = 1'b0;
                    2'b10: q_d[i] = 1'b1;
                    2'b11: q_d[i] = toggle_en[i] ? ~q_q[i] : q_q[i];
                endcase
            end
        end
    end

    assign q_change  = (q_d != q_q);
    assign changed_d = q_change;

    // Clear takes precedence over counting the same cycle's change; saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (q_change && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RESET_VAL;
            changed_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign Q          = q_q;
    assign changed    = changed_q;
    assign change_cnt = cnt_q;

endmodule

// File: tb/tb_jk_register_bank.sv
// Self-checking bench for jk_register_bank (WIDTH=8, CNT_W=4, RESET_VAL=0).
// Stimulus pushes the expected post-edge state into a queue; a monitor pops and
// compares one entry after every rising edge for which an entry is pending.

module tb_jk_register_bank;

    logic       clk = 1'b0;
    logic       reset, en, load, cnt_clr;
    logic [7:0] load_data, J, K, tmask;
    logic [7:0] Q;
    logic       changed;
    logic [3:0] change_cnt;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       ch;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    jk_register_bank #(
        .WIDTH     (8),
        .CNT_W     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .load_data  (load_data),
        .J          (J),
        .K          (K),
`ifdef JK_BANK_TOGGLE_MASK_EN
        .tmask      (tmask),
`endif
        .cnt_clr    (cnt_clr),
        .Q          (Q),
        .changed    (changed),
        .change_cnt (change_cnt)
    );

    // Monitor: compares outputs 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (Q !== e.q) begin
                    failed++;
                    $display("FAIL %s Q: got %h expected %h", e.name, Q, e.q);
                end
                tests++;
                if (changed !== e.ch) begin
                    failed++;
                    $display("FAIL %s changed: got %b expected %b", e.name, changed, e.ch);
                end
                tests++;
                if (change_cnt !== e.cnt) begin
                    failed++;
                    $display("FAIL %s change_cnt: got %h expected %h", e.name, change_cnt, e.cnt);
                end
            end
        end
    end

    // Drives one cycle of inputs away from the active edge and queues the expectation.
    task automatic step(input string name, input logic r, input logic ld,
                        input logic [7:0] ldd, input logic e, input logic [7:0] j,
                        input logic [7:0] k, input logic clr, input logic [7:0] eq,
                        input logic ech, input logic [3:0] ecnt);
        exp_t x;
        @(negedge clk);
        reset     = r;
        load      = ld;
        load_data = ldd;
        en        = e;
        J         = j;
        K         = k;
        cnt_clr   = clr;
        x.name = name;
        x.q    = eq;
        x.ch   = ech;
        x.cnt  = ecnt;
        sb.push_back(x);
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] eq;
        logic [3:0] ec;
        tmask = 8'hFF;

        // Reset wins over load/en.
        step("reset0", 1, 1, 8'hFF, 1, 8'h00, 8'h00, 0, 8'h00, 0, 4'h0);
        step("reset1", 1, 1, 8'hFF, 1, 8'h00, 8'h00, 0, 8'h00, 0, 4'h0);

        // JK codes.
        step("jk_set_clr", 0, 0, 8'h00, 1, 8'hF0, 8'h0F, 0, 8'hF0, 1, 4'h1);
        step("jk_toggle",  0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, 8'h0F, 1, 4'h2);
        step("jk_hold",    0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 8'h0F, 0, 4'h2);

        // Priority.
        step("load_over_jk", 0, 1, 8'hA5, 1, 8'hFF, 8'hFF, 0, 8'hA5, 1, 4'h3);
        step("load_same",    0, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 4'h3);
        step("en_low_hold",  0, 0, 8'h00, 0, 8'hFF, 8'h00, 0, 8'hA5, 0, 4'h3);
        step("clr_on_zeros", 0, 0, 8'h00, 1, 8'h00, 8'h5A, 0, 8'hA5, 0, 4'h3);

        // Saturation: cnt goes 4..15 then holds.
        for (int n = 1; n <= 20; n++) begin
            eq = (n % 2 == 1) ? 8'h5A : 8'hA5;
            ec = (3 + n > 15) ? 4'hF : 4'(3 + n);
            step("sat_toggle", 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, eq, 1, ec);
        end
        step("clr_with_toggle", 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 1, 8'h5A, 1, 4'h0);

        for (int n = 1; n <= 5; n++) begin
            eq = (n % 2 == 1) ? 8'hA5 : 8'h5A;
            step("count_up", 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, eq, 1, 4'(n));
        end

        // Reset mid-run, then first toggle after reset.
        step("reset_mid",   1, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, 8'h00, 0, 4'h0);
        step("after_reset", 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, 8'hFF, 1, 4'h1);

        // Toggle mask.
        step("load_zero", 0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 4'h2);
        tmask = 8'h0F;
`ifdef JK_BANK_TOGGLE_MASK_EN
        step("mask_toggle", 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, 8'h0F, 1, 4'h3);
`else
        step("mask_toggle", 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, 8'hFF, 1, 4'h3);
`endif
        tmask = 8'hFF;

        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
